mul_div_ctrl: RTL and testbench
===============================

# mul_div_ctrl

Multi-cycle multiply/divide sequencer in the EX stage. Accepts MULT/MULTU/DIV/DIVU operations and runs a 1-bit-per-cycle shift-add multiplier or restoring divider on operand magnitudes, then applies the sign correction. Holds the pipeline with `stall` while busy and presents the 64-bit result as `hi`/`lo` with a one-cycle `done` pulse; the HI/LO architectural registers are written elsewhere.

## Interface
- `DATA_WIDTH`, 32, operand width; the iteration counter is clog2(DATA_WIDTH)+1 bits wide.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EX holds a candidate mul/div instruction this cycle.
- `funct`  in  6  0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; any other value means start is ignored.
- `flush`  in  1  abort the current operation; no result is produced.
- `operand_a`  in  DATA_WIDTH  rs value (multiplicand or dividend).
- `operand_b`  in  DATA_WIDTH  rt value (multiplier or divisor).
- `stall`  out  1  holds IF/ID/EX while the operation is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid this cycle.
- `hi`  out  DATA_WIDTH  product[63:32] or remainder.
- `lo`  out  DATA_WIDTH  product[31:0] or quotient.
- `div_by_zero`  out  1  set together with `done` when the divisor was 0.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **IDLE**
  - `start` with a valid funct and no `flush` latches the signed flag, magnitudes |a| and |b| (unsigned ops take the raw values), neg_q = sa^sb and neg_r = sa. Signed flags are taken from bit 31 only for MULT and DIV.
  - Counter is cleared.
  - Next state is MUL or DIV. DIV/DIVU with b==0 goes directly to DONE.
- **MUL**: each cycle, when multiplier bit 0 is 1, add the multiplicand to the upper half of the 64-bit accumulator. Then shift the accumulator and multiplier right 1. After DATA_WIDTH iterations the next state is FIX.
- **DIV**: each cycle, shift {rem, quo} left 1 and trial-subtract the divisor from rem.
  - Non-negative difference: keep it and set quo bit 0.
  - Otherwise restore rem.
  - After DATA_WIDTH iterations the next state is FIX.
- **FIX** (1 cycle):
  - MULT with neg_q: negate the 64-bit product (two's complement).
  - DIV: negate quo if neg_q, negate rem if neg_r.
  - Result is registered into `hi`/`lo`. Next state is DONE.
- **DONE** (1 cycle): `done`=1, then return to IDLE. A new `start` is accepted only in IDLE, so at most one op is in flight.
- **Divide by zero**: `hi`=operand_a (raw), `lo`=all ones, `div_by_zero`=1.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0 through the normal path. No special case.
- **Flush**
  - In any non-IDLE state, `flush` forces IDLE next cycle. No `done` is produced and `hi`/`lo`/`div_by_zero` are unchanged.
  - `flush` in the same cycle as `start` wins: the start is not accepted.
- `start` while not in IDLE is ignored.
- `hi`/`lo` hold the last result until the next DONE.

## Timing
- **Reset values**: state IDLE, `hi`=0, `lo`=0, `done`=0, `div_by_zero`=0, `stall`=0.
- **stall**: combinational; = (state ∉ {IDLE, DONE}) | (state==IDLE & start & valid funct & !flush).
  - The accepting cycle therefore already stalls.
  - `stall` is 0 in DONE so EX advances in the same cycle it consumes `hi`/`lo`.
- **Latency**, with start accepted at the edge ending cycle T:
  - MUL or DIV: cycles T+1..T+32. FIX: T+33. `done` high in T+34.
  - `stall` is high T..T+33 (34 cycles).
- **Divide by zero**: `done` high in T+1; `stall` high only in T.
- **Back-to-back**: the earliest next start is the cycle after DONE (T+35).
- **Flush timing**: `flush` in cycle k drops `stall` in cycle k+1. `rst` mid-operation behaves identically and also clears outputs.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> `done` at T+34, `hi`=0xFFFFFFFE `lo`=0x00000001, `stall` high exactly 34 cycles.
- MULT a=0xFFFFFFFD(−3) b=7 -> `hi`=0xFFFFFFFF `lo`=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> `hi`=0x40000000 `lo`=0.
- DIV a=0xFFFFFFF9(−7) b=2 -> `lo`=0xFFFFFFFD `hi`=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> `lo`=0x80000000 `hi`=0. DIVU a=100 b=7 -> `lo`=14 `hi`=2.
- DIVU a=0x1234 b=0 -> `done` and `div_by_zero` at T+1, `hi`=0x1234 `lo`=0xFFFFFFFF. The next normal DIVU clears `div_by_zero`.
- MULTU 3×5 completes (`lo`=15); then start DIVU, flush at T+10 -> `stall`=0 from T+11, no `done`, `lo` stays 15. A MULTU 6×7 started afterwards gives `lo`=42 at its T+34.
- Error paths:
  - start with funct=0x20 -> no stall, no done.
  - start during busy with different operands -> ignored, first result intact.
  - start and flush in the same cycle -> ignored.
  - rst at T+5 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/mul_div_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Runs a 1-bit-per-cycle shift-add multiplier or restoring divider on operand
// magnitudes, applies sign correction, and presents the result on hi/lo with
// a one-cycle done pulse. stall holds the front of the pipeline while busy.
module mul_div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  // Operation context latched at accept
  logic [2*DW-1:0] acc;
  logic [DW-1:0]   opa;
  logic [DW-1:0]   opb;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic            is_div;

  // Decode / accept signals
  logic          valid_op;
  logic          op_is_div;
  logic          op_signed;
  logic          accept;
  logic          b_zero;
  logic          sa;
  logic          sb;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic          last_iter;

  // Datapath step / fixup results
  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_next;
  logic [DW+1:0]   div_diff;
  logic [2*DW-1:0] div_next;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quo_fix;
  logic [DW-1:0]   rem_fix;

  // Instruction decode, operand magnitudes and accept condition
  always_comb begin
    valid_op  = (funct == F_MULT) || (funct == F_MULTU) ||
                (funct == F_DIV)  || (funct == F_DIVU);
    op_is_div = (funct == F_DIV)  || (funct == F_DIVU);
    op_signed = (funct == F_MULT) || (funct == F_DIV);
    accept    = (state == IDLE) && start && valid_op && !flush;
    b_zero    = (operand_b == '0);
    sa        = op_signed && operand_a[DW-1];
    sb        = op_signed && operand_b[DW-1];
    mag_a     = sa ? (~operand_a + 1'b1) : operand_a;
    mag_b     = sb ? (~operand_b + 1'b1) : operand_b;
    last_iter = (cnt == CW'(DW-1));
  end

  // One shift-add / restoring-divide iteration plus the final sign fixup.
  // The divide trial subtraction is one bit wider than the divisor because the
  // shifted partial remainder can exceed DW bits before the subtract.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DW-1:DW]} + (opb[0] ? {1'b0, opa} : '0);
    mul_next = {mul_sum, acc[DW-1:1]};
    div_diff = {1'b0, acc[2*DW-1:DW-1]} - {2'b00, opb};
    div_next = div_diff[DW+1] ? {acc[2*DW-2:0], 1'b0}
                              : {div_diff[DW-1:0], acc[DW-2:0], 1'b1};
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quo_fix  = neg_q ? (~acc[DW-1:0] + 1'b1) : acc[DW-1:0];
    rem_fix  = neg_r ? (~acc[2*DW-1:DW] + 1'b1) : acc[2*DW-1:DW];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs; flush overrides any busy state
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_is_div && b_zero) begin
            state_next = DONE;
          end else if (op_is_div) begin
            state_next = DIV;
          end else begin
            state_next = MUL;
          end
        end
        stall = accept;
      end
      MUL: begin
        if (last_iter) state_next = FIX;
        stall = 1'b1;
      end
      DIV: begin
        if (last_iter) state_next = FIX;
        stall = 1'b1;
      end
      FIX: begin
        state_next = DONE;
        stall      = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (flush && (state != IDLE)) state_next = IDLE;
  end

  // Datapath registers and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_div      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            is_div <= op_is_div;
            opa    <= mag_a;
            opb    <= mag_b;
            acc    <= op_is_div ? {{DW{1'b0}}, mag_a} : '0;
            // Divide by zero skips iteration; the result is posted here so it
            // is visible during the DONE cycle that follows.
            if (op_is_div && b_zero) begin
              hi          <= operand_a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          opb <= opb >> 1;
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*DW-1:DW];
              lo <= prod_fix[DW-1:0];
            end
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Scoreboard bench for mul_div_ctrl: the driver pushes expected results and
// completion cycles, a negedge monitor pops and compares on every done pulse.
module tb_mul_div_ctrl;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic        flush = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mul_div_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .funct(funct),
    .flush(flush),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .stall(stall),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_hi", {32'h0, hi}, {32'h0, mon_e.hi});
        chk("result_lo", {32'h0, lo}, {32'h0, mon_e.lo});
        chk("result_dbz", {63'h0, div_by_zero}, {63'h0, mon_e.dbz});
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Issue one op (called #1 after a rising edge) and count its stall cycles.
  // If poke > 0, a second start with other operands is driven in cycle T+poke.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez,
                        input int lat, input int poke);
    exp_t e;
    int   stalls;
    bit   seen;
    e.hi = eh; e.lo = el; e.dbz = ez; e.cyc = cyc + lat;
    sb_q.push_back(e);
    start = 1'b1; funct = f; operand_a = a; operand_b = b;
    stalls = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) seen = 1'b1;
      @(posedge clk); #1;
      if (poke > 0 && i + 1 == poke) begin
        start = 1'b1; funct = F_MULTU; operand_a = 32'd9; operand_b = 32'd9;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", {63'h0, seen}, 64'h1);
    chk("stall_cycles", 64'(stalls), 64'(lat));
  endtask

  // Wait n cycles checking that stall stays low
  task automatic idle_cycles(input string name, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stall) hits++;
      @(posedge clk); #1;
    end
    chk(name, 64'(hits), 64'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", {32'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_dbz", {63'h0, div_by_zero}, 64'h0);
    chk("reset_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;

    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 0);
    run_op(F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 0);
    run_op(F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 0);
    run_op(F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, 0);
    run_op(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0);
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 0);
    // Start during busy must be ignored
    run_op(F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 5);
    run_op(F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1, 0);
    run_op(F_DIVU,  32'd50,       32'd5,        32'd0,        32'd10,       1'b0, 34, 0);
    run_op(F_MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 34, 0);

    // Flush a DIVU at T+10: stall drops at T+11, no done, result untouched
    start = 1'b1; funct = F_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_stall", {63'h0, stall}, 64'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("after_flush_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    idle_cycles("flush_quiet_stall", 40);
    chk("flush_keep_lo", {32'h0, lo}, 64'd15);
    chk("flush_keep_hi", {32'h0, hi}, 64'd0);

    run_op(F_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 34, 0);

    // Invalid funct: no stall, no done
    start = 1'b1; funct = 6'h20; operand_a = 32'd5; operand_b = 32'd5;
    @(negedge clk);
    chk("bad_funct_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles("bad_funct_quiet", 40);

    // Start with flush in the same cycle: not accepted
    start = 1'b1; flush = 1'b1; funct = F_MULTU; operand_a = 32'd2; operand_b = 32'd3;
    @(negedge clk);
    chk("start_flush_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    idle_cycles("start_flush_quiet", 40);
    chk("start_flush_keep_lo", {32'h0, lo}, 64'd42);

    run_op(F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 0);

    // Reset at T+5 of a running multiply
    start = 1'b1; funct = F_MULTU; operand_a = 32'hFFFFFFFF; operand_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", {32'h0, hi}, 64'h0);
    chk("midrst_lo", {32'h0, lo}, 64'h0);
    chk("midrst_done", {63'h0, done}, 64'h0);
    chk("midrst_dbz", {63'h0, div_by_zero}, 64'h0);
    chk("midrst_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    idle_cycles("midrst_quiet", 40);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
